// File: rtl/sram.sv
// sram: single-port byte-wide RAM, 1-cycle registered read, tri-state dout.
// Optional even-parity storage and perr flag when SRAM_PARITY_EN is defined.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears read path only, not the array)
//   cs    chip select, active-high
//   wr    write strobe, active-high
//   rd    read enable, active-low
//   addr  word address
//   din   write data
//   dout  read data, high-Z when not driving
//   perr  parity error, only with SRAM_PARITY_EN
module sram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
`ifdef SRAM_PARITY_EN
  output logic              perr,
`endif
  output logic [DATA_W-1:0] dout
);

`ifdef SRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int WORD_W = DATA_W + PAR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rword;
  logic [DATA_W-1:0] rdata;
  logic              oe;
  logic              in_range;
  logic              wen;
  logic              ren;

  // Only matters when DEPTH is smaller than the address space.
  assign in_range = int'(addr) < DEPTH;

  assign wen = cs && wr && in_range;
  assign ren = cs && !rd && in_range;

`ifdef SRAM_PARITY_EN
  // Stored bit makes the whole word even parity.
  assign wword = {^din, din};
`else
  assign wword = din;
`endif

  assign rword = mem[addr];

  // Array is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wen) begin
      mem[addr] <= wword;
    end
  end

  // Nonblocking update gives read-before-write on a same-address access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      oe    <= 1'b0;
    end else begin
      oe <= ren;
      if (ren) begin
        rdata <= rword[DATA_W-1:0];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic pbad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbad <= 1'b0;
    end else if (ren) begin
      pbad <= ^rword;
    end
  end

  assign perr = oe && pbad;
`endif

  assign dout = oe ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram.sv
// tb_sram: random + directed bench for sram against an array-level model.
// Two DUT copies sit on pulled-up and pulled-down buses to observe high-Z.
module tb_sram;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [7:0] addr;
  logic [7:0] din;
  wire  [7:0] bus_up;
  wire  [7:0] bus_dn;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: plain array with written flags.
  logic [7:0] m_mem [256];
  bit         m_val [256];
  bit         e_oe = 1'b0;
  bit         e_known = 1'b0;
  logic [7:0] e_data = 8'h00;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup   (bus_up[i]);
    pulldown (bus_dn[i]);
  end

  sram u_up (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .wr   (wr),
    .rd   (rd),
    .addr (addr),
    .din  (din),
`ifdef SRAM_PARITY_EN
    .perr (),
`endif
    .dout (bus_up)
  );

  sram u_dn (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .wr   (wr),
    .rd   (rd),
    .addr (addr),
    .din  (din),
`ifdef SRAM_PARITY_EN
    .perr (),
`endif
    .dout (bus_dn)
  );

  function automatic bit is_z();
    return (bus_up === 8'hFF) && (bus_dn === 8'h00);
  endfunction

  task automatic cycle(input bit c, input bit w, input bit r,
                       input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    #1;
    cs = c;
    wr = w;
    rd = r;
    addr = a;
    din = d;
    @(posedge clk);
    if (c && !r) begin
      e_oe    = 1'b1;
      e_known = m_val[a];
      e_data  = m_mem[a];
    end else begin
      e_oe = 1'b0;
    end
    if (c && w) begin
      m_mem[a] = d;
      m_val[a] = 1'b1;
    end
  endtask

  task automatic lit(input string name, input bit want_z,
                     input logic [7:0] val);
    #2;
    vectors++;
    if (want_z) begin
      if (!is_z()) begin
        miscompares++;
        $display("FAIL %s: got up=%h dn=%h want z", name, bus_up, bus_dn);
      end
    end else if (bus_up !== val || bus_dn !== val) begin
      miscompares++;
      $display("FAIL %s: got up=%h dn=%h want %h", name, bus_up, bus_dn, val);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      vectors++;
      if (!e_oe) begin
        if (!is_z()) begin
          miscompares++;
          $display("FAIL cmp_idle: got up=%h dn=%h want z", bus_up, bus_dn);
        end
      end else if (e_known) begin
        if (bus_up !== e_data || bus_dn !== e_data) begin
          miscompares++;
          $display("FAIL cmp_read: got up=%h dn=%h want %h",
                   bus_up, bus_dn, e_data);
        end
      end else if (is_z()) begin
        miscompares++;
        $display("FAIL cmp_drive: got z want driven");
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) m_val[i] = 1'b0;
    rst = 1'b1;
    cs = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    addr = 8'h00;
    din = 8'h00;
    repeat (2) @(posedge clk);
    lit("reset_z", 1'b1, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    rd = 1'b1;
    cs = 1'b0;
    e_oe = 1'b0;
    chk_en = 1'b1;

    cycle(1, 1, 1, 8'h01, 8'h33);
    cycle(1, 0, 0, 8'h01, 8'h00);
    lit("first_read", 1'b0, 8'h33);

    cycle(0, 1, 1, 8'hA5, 8'hA2);
    cycle(1, 1, 1, 8'hA5, 8'h00);
    cycle(1, 0, 0, 8'hA5, 8'h00);
    lit("wr_blocked", 1'b0, 8'h00);

    cycle(1, 1, 1, 8'hA5, 8'hA2);
    cycle(1, 0, 0, 8'hA5, 8'h00);
    lit("wr_rd", 1'b0, 8'hA2);
    cycle(1, 0, 1, 8'hA5, 8'h00);
    lit("rd_high_z", 1'b1, 8'h00);

    cycle(0, 0, 0, 8'hA5, 8'h00);
    lit("desel_z", 1'b1, 8'h00);
    cycle(1, 1, 1, 8'h5A, 8'hA2);
    cycle(1, 0, 0, 8'h5A, 8'h00);
    lit("rd_5a", 1'b0, 8'hA2);
    cycle(1, 0, 0, 8'hA5, 8'h00);
    lit("rd_a5", 1'b0, 8'hA2);

    cycle(1, 1, 1, 8'h10, 8'h11);
    cycle(1, 1, 0, 8'h10, 8'h22);
    lit("rbw_old", 1'b0, 8'h11);
    cycle(1, 0, 0, 8'h10, 8'h00);
    lit("rbw_new", 1'b0, 8'h22);

    cycle(1, 0, 0, 8'hA5, 8'h00);
    lit("pre_rst", 1'b0, 8'hA2);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (!is_z()) begin
      miscompares++;
      $display("FAIL rst_mid: got up=%h dn=%h want z", bus_up, bus_dn);
    end
    rst = 1'b0;
    e_oe = 1'b0;
    cycle(1, 0, 1, 8'h00, 8'h00);
    cycle(1, 0, 0, 8'hA5, 8'h00);
    lit("post_rst", 1'b0, 8'hA2);

    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      a = (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, a, 8'($urandom));
    end
    cycle(0, 0, 1, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
